// File: rtl/jtframe_dpram_pkg.sv
// Shared types for the jtframe dual-port RAM and its reset-time clear sequencer.
package jtframe_dpram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/jtframe_ram_clr.sv
// Reset-time clear sequencer: sweeps every address once, writing zero through port 0.
// Only instantiated when JTFRAME_DPRAM_CLR_EN is defined.
module jtframe_ram_clr
   import jtframe_dpram_pkg::*;
#(
   parameter int unsigned aw = 10
) (
   input  logic          clk,
   input  logic          rst,
   output logic [aw-1:0] clr_addr,
   output logic          clr_we,
   output logic          clr_busy
);

   localparam logic [aw-1:0] last_addr = '1;

   clr_state_e    state_q, state_d;
   logic [aw-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   // Next-state logic; busy tracks the registered state so it is always CLEAR-exact
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      case (state_q)
         IDLE:  state_d = IDLE;
         CLEAR: begin
            cnt_d = cnt_q + aw'(1);
            if (cnt_q == last_addr) state_d = DONE;
         end
         DONE:  state_d = DONE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign clr_addr = cnt_q;
   assign clr_we   = busy_q;
   assign clr_busy = busy_q;

endmodule

// File: rtl/jtframe_dual_port_ram.sv
// True dual-port synchronous RAM, one clock, registered read-old outputs.
// Optional zero-fill on reset when JTFRAME_DPRAM_CLR_EN is defined.
module jtframe_dual_port_ram #(
   parameter int unsigned dw = 8,
   parameter int unsigned aw = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [dw-1:0] data0,
   input  logic [aw-1:0] addr0,
   input  logic          we0,
   output logic [dw-1:0] q0,
   input  logic [dw-1:0] data1,
   input  logic [aw-1:0] addr1,
   input  logic          we1,
   output logic [dw-1:0] q1,
   output logic          clr_busy
);

   localparam int unsigned depth = 1 << aw;

   logic [dw-1:0] mem [0:depth-1];

   logic [aw-1:0] a0;
   logic [dw-1:0] d0;
   logic          w0, w1, blank;

`ifdef JTFRAME_DPRAM_CLR_EN
   logic [aw-1:0] clr_addr;
   logic          clr_we;

   jtframe_ram_clr #(.aw(aw)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_addr (clr_addr),
      .clr_we   (clr_we),
      .clr_busy (clr_busy)
   );

   // Sequencer owns port 0 during the sweep; user writes are dropped on both ports
   always_comb begin
      a0    = clr_busy ? clr_addr : addr0;
      d0    = clr_busy ? '0 : data0;
      w0    = clr_busy ? clr_we : we0;
      w1    = we1 & ~clr_busy;
      blank = rst | clr_busy;
   end
`else
   assign clr_busy = 1'b0;

   always_comb begin
      a0    = addr0;
      d0    = data0;
      w0    = we0;
      w1    = we1;
      blank = rst;
   end
`endif

   // Port 1 write is last so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (blank) begin
         q0 <= '0;
         q1 <= '0;
      end else begin
         q0 <= mem[a0];
         q1 <= mem[addr1];
      end
      if (w0) mem[a0]    <= d0;
      if (w1) mem[addr1] <= data1;
   end

endmodule

// File: tb/tb_jtframe_dual_port_ram.sv
// Self-checking bench for jtframe_dual_port_ram (dw=8, aw=10); covers JTFRAME_DPRAM_CLR_EN if defined.
module tb_jtframe_dual_port_ram;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data0, data1, q0, q1;
   logic [9:0] addr0, addr1;
   logic       we0, we1, clr_busy;

   typedef struct {
      logic       c0;
      logic [7:0] v0;
      logic       c1;
      logic [7:0] v1;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model [0:1023];
   int         n_tests = 0;
   int         n_fail  = 0;

   jtframe_dual_port_ram #(.dw(8), .aw(10)) dut (
      .clk(clk), .rst(rst),
      .data0(data0), .addr0(addr0), .we0(we0), .q0(q0),
      .data1(data1), .addr1(addr1), .we1(we1), .q1(q1),
      .clr_busy(clr_busy)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus and push the outputs expected after the next edge
   task automatic drive(input logic r,
                        input logic [9:0] a0, input logic w0, input logic [7:0] d0,
                        input logic [9:0] a1, input logic w1, input logic [7:0] d1,
                        input logic c0, input logic c1);
      exp_t e;
      rst = r; addr0 = a0; we0 = w0; data0 = d0; addr1 = a1; we1 = w1; data1 = d1;
      e.c0 = c0; e.c1 = c1;
      e.v0 = r ? 8'h00 : model[a0];
      e.v1 = r ? 8'h00 : model[a1];
      sb.push_back(e);
`ifdef JTFRAME_DPRAM_CLR_EN
      if (!r) begin
         if (w0) model[a0] = d0;
         if (w1) model[a1] = d1;
      end
`else
      if (w0) model[a0] = d0;
      if (w1) model[a1] = d1;
`endif
   endtask

   task automatic wait_clear(input string name);
`ifdef JTFRAME_DPRAM_CLR_EN
      int n = 0;
      while (clr_busy && n < 2000) begin
         drive(1'b0, 10'd0, 1'b0, 8'd0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0);
         @(posedge clk); #1;
         void'(sb.pop_front());
         n++;
      end
      n_tests++;
      if (clr_busy) begin
         n_fail++;
         $display("FAIL %s clear sweep timeout busy=%b", name, clr_busy);
      end
      for (int i = 0; i < 1024; i++) model[i] = 8'h00;
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 10'(i), 1'b0, 8'd0, 10'(i + 1), 1'b0, 8'd0, 1'b1, 1'b1);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (q0 !== e.v0 || q1 !== e.v1) begin
            n_fail++;
            $display("FAIL reset q0=%h q1=%h want %h %h", q0, q1, e.v0, e.v1);
         end
`ifdef JTFRAME_DPRAM_CLR_EN
         n_tests++;
         if (clr_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy clr_busy=%b want 1", clr_busy);
         end
`else
         n_tests++;
         if (clr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy clr_busy=%b want 0", clr_busy);
         end
`endif
      end
   endtask

   task automatic test_clear();
`ifdef JTFRAME_DPRAM_CLR_EN
      int n = 0;
      exp_t e;
      while (clr_busy && n < 2000) begin
         rst = 1'b0; we0 = 1'b1; we1 = 1'b1;
         addr0 = 10'($urandom_range(1023)); addr1 = 10'($urandom_range(1023));
         data0 = 8'hFF; data1 = 8'hEE;
         @(posedge clk); #1;
         n++;
         if (q0 !== 8'h00 || q1 !== 8'h00) begin
            n_tests++; n_fail++;
            $display("FAIL clear_q q0=%h q1=%h want 00", q0, q1);
         end
      end
      n_tests++;
      if (n != 1024) begin
         n_fail++;
         $display("FAIL clear_len busy cycles=%0d want 1024", n);
      end
      for (int i = 0; i < 1024; i++) model[i] = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         drive(1'b0, 10'(i), 1'b0, 8'd0, 10'(1023 - i), 1'b0, 8'd0, 1'b1, 1'b1);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (q0 !== e.v0 || q1 !== e.v1) begin
            n_fail++;
            $display("FAIL clear_zero addr=%0d q0=%h q1=%h want 00", i, q0, q1);
         end
      end
`else
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 10'd0, 1'b0, 8'd0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0);
         @(posedge clk); #1;
         void'(sb.pop_front());
         n_tests++;
         if (clr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_off clr_busy=%b want 0", clr_busy);
         end
      end
`endif
   endtask

   task automatic test_write_read();
      exp_t e;
      drive(1'b0, 10'h123, 1'b1, 8'hA5, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      void'(sb.pop_front());
      drive(1'b0, 10'h123, 1'b0, 8'h00, 10'h123, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (q1 !== e.v1 || e.v1 !== 8'hA5) begin
         n_fail++;
         $display("FAIL write_read q1=%h want %h", q1, e.v1);
      end
      n_tests++;
      if (q0 !== e.v0) begin
         n_fail++;
         $display("FAIL write_read q0=%h want %h", q0, e.v0);
      end
   endtask

   task automatic test_rdw();
      exp_t e;
      drive(1'b0, 10'h010, 1'b1, 8'h11, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      void'(sb.pop_front());
      drive(1'b0, 10'h010, 1'b1, 8'h22, 10'h010, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (q0 !== e.v0 || q1 !== e.v1) begin
         n_fail++;
         $display("FAIL rdw_old q0=%h q1=%h want %h", q0, q1, e.v0);
      end
      drive(1'b0, 10'h010, 1'b0, 8'h00, 10'h010, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (q0 !== e.v0 || q1 !== e.v1) begin
         n_fail++;
         $display("FAIL rdw_new q0=%h q1=%h want %h", q0, q1, e.v0);
      end
   endtask

   task automatic test_collision();
      exp_t e;
      drive(1'b0, 10'h3FF, 1'b1, 8'h55, 10'h3FF, 1'b1, 8'hAA, 1'b0, 1'b0);
      @(posedge clk); #1;
      void'(sb.pop_front());
      drive(1'b0, 10'h3FF, 1'b0, 8'h00, 10'h3FF, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (q0 !== e.v0 || q1 !== e.v1) begin
         n_fail++;
         $display("FAIL collision q0=%h q1=%h want %h", q0, q1, e.v0);
      end
   endtask

   task automatic test_read_erase();
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 10'h200 + 10'(i), 1'b1, 8'h80 + 8'(i), 10'h000, 1'b0, 8'h00, 1'b0, 1'b0);
         @(posedge clk); #1;
         void'(sb.pop_front());
      end
      // Port 1 reads and erases while port 0 writes a different region
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 16; i++) begin
            drive(1'b0, 10'h300 + 10'(i), 1'b1, 8'(i * 3 + pass),
                  10'h200 + 10'(i), 1'b1, 8'h00, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q1 !== e.v1) begin
               n_fail++;
               $display("FAIL read_erase pass=%0d i=%0d q1=%h want %h", pass, i, q1, e.v1);
            end
         end
      end
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 10'h300 + 10'(i), 1'b0, 8'h00, 10'h200 + 10'(i), 1'b0, 8'h00, 1'b1, 1'b1);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (q0 !== e.v0 || q1 !== e.v1) begin
            n_fail++;
            $display("FAIL dual_write i=%0d q0=%h q1=%h want %h %h", i, q0, q1, e.v0, e.v1);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      drive(1'b0, 10'h123, 1'b0, 8'h00, 10'h010, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      void'(sb.pop_front());
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 10'h123, 1'b0, 8'h00, 10'h050 + 10'(i), 1'b1, 8'h77 + 8'(i), 1'b1, 1'b1);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (q0 !== e.v0 || q1 !== e.v1) begin
            n_fail++;
            $display("FAIL reset_mid q0=%h q1=%h want 00", q0, q1);
         end
      end
      wait_clear("reset_mid");
      drive(1'b0, 10'h123, 1'b0, 8'h00, 10'h050, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (q0 !== e.v0 || q1 !== e.v1) begin
         n_fail++;
         $display("FAIL reset_keep q0=%h q1=%h want %h %h", q0, q1, e.v0, e.v1);
      end
      drive(1'b0, 10'h051, 1'b0, 8'h00, 10'h010, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (q0 !== e.v0 || q1 !== e.v1) begin
         n_fail++;
         $display("FAIL reset_keep2 q0=%h q1=%h want %h %h", q0, q1, e.v0, e.v1);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model[i] = 8'h00;
      rst = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
      @(posedge clk); #1;
      test_reset();
      test_clear();
      test_write_read();
      test_rdw();
      test_collision();
      test_read_erase();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
